// File: rtl/serial_add_and_sub_pkg.sv
// Shared FSM state encoding for the bit-serial add/sub unit.
// No timing of its own; constants only.
// No flow control; imported by the top-level FSM.
package serial_add_and_sub_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_add_and_sub_full_adder.sv
// One-bit full adder cell, shared with the ripple-carry add/sub units.
// Purely combinational, zero latency.
// No flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_add_and_sub.sv
// Bit-serial adder/subtractor: sum = a + (b ^ {WIDTH{M}}) + c_in, one bit per clock.
// Latency WIDTH cycles from the accepting edge; one-cycle done pulse, result held.
// start is only honoured in IDLE or DONE; requests during RUN are dropped, not queued.
module serial_add_and_sub
  import serial_add_and_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             M,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  // Only WIDTH-1 bits are ever buffered: the last sum bit goes straight to the output register.
  logic [WIDTH-2:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_shift;

  full_adder u_fa (
    .a     (opa_q[0]),
    .b     (opb_q[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // New sum bit enters from the MSB end so bit 0 lands in position 0 after WIDTH shifts.
  assign res_shift = {fa_s, res_q};

  // Next-state logic: capture on accepted start, shift one bit per RUN cycle, publish on the last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{M}};
          carry_d = c_in;
          cnt_d   = '0;
          res_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = res_shift[WIDTH-1:1];
        carry_d = fa_co;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = res_shift;
          c_out_d = fa_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; async reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_and_sub.sv
// Directed bench for serial_add_and_sub with a result scoreboard.
// Expected {c_out,sum} pushed when an op is started, popped on each done pulse.
// Checks reset, latency, hold, ignore-while-busy, back-to-back, abort and all 4-bit cases.
module tb_serial_add_and_sub;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             c_in, M;
  logic             busy, done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_done    = 0;
  logic [WIDTH:0] exp_q[$];

  serial_add_and_sub #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .M       (M),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .c_out   (c_out)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH:0] ref_model(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                               input logic rc, input logic rm);
    logic [WIDTH:0] bb;
    bb = {1'b0, rb};
    if (rm) bb = {1'b0, ~rb};
    return {1'b0, ra} + bb + {{WIDTH{1'b0}}, rc};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one request for a single edge, record its expected result, then scramble inputs.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_, input logic tc, input logic tm);
    a = ta; b = tb_; c_in = tc; M = tm; start = 1'b1;
    exp_q.push_back(ref_model(ta, tb_, tc, tm));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'($urandom); M = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!done && cycles < 40);
    chk({tag, "_seen"}, {31'd0, done}, 32'd1);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (busy && done) chk("busy_done_overlap", {31'd0, busy & done}, 32'd0);
      if (done === 1'b1) begin
        n_done++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [WIDTH:0] e;
          e = exp_q.pop_front();
          chk("result", {27'd0, c_out, sum}, {27'd0, e});
        end
      end
    end
  end

  initial begin
    int cyc;
    int done_snap;
    logic [WIDTH:0] held;

    // Reset held with live, random stimulus and start asserted.
    reset_n = 1'b0; start = 1'b1;
    a = WIDTH'($urandom); b = WIDTH'($urandom); c_in = 1'b1; M = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {28'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, c_out}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

    // Adds, with exact latency on the first one.
    start_op(4'd5, 4'd7, 1'b0, 1'b0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk("lat_busy", {31'd0, busy}, 32'd1);
      chk("lat_done_low", {31'd0, done}, 32'd0);
      chk("lat_sum_hidden", {28'd0, sum}, 32'd0);
    end
    @(negedge clk);
    chk("lat_done_high", {31'd0, done}, 32'd1);
    chk("lat_busy_low", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("add1_sum", {28'd0, sum}, 32'd12);

    start_op(4'd15, 4'd2, 1'b0, 1'b0);
    wait_done("add2", cyc);
    chk("add2_latency", cyc, WIDTH + 1);

    // Subtracts: no borrow, then borrow.
    start_op(4'd13, 4'd7, 1'b1, 1'b1);
    wait_done("sub1", cyc);
    start_op(4'd2, 4'd6, 1'b1, 1'b1);
    wait_done("sub2", cyc);
    @(negedge clk);

    // Start pulsed mid-RUN with new operands must be ignored.
    start_op(4'd7, 4'd1, 1'b1, 1'b1);
    @(posedge clk); #1;
    a = 4'd0; b = 4'd0; c_in = 1'b0; M = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 4'd9; b = 4'd3;
    wait_done("busy_ign", cyc);
    repeat (4) @(negedge clk);
    chk("hold_sum", {28'd0, sum}, 32'd6);
    chk("hold_cout", {31'd0, c_out}, 32'd1);
    chk("ignored_no_op", {31'd0, busy}, 32'd0);

    // Back-to-back: start held high across two operations.
    a = 4'd4; b = 4'd3; c_in = 1'b0; M = 1'b0; start = 1'b1;
    exp_q.push_back(ref_model(4'd4, 4'd3, 1'b0, 1'b0));
    @(posedge clk); #1;
    a = 4'd1; b = 4'd3;
    exp_q.push_back(ref_model(4'd1, 4'd3, 1'b0, 1'b0));
    wait_done("b2b_first", cyc);
    wait_done("b2b_second", cyc);
    start = 1'b0;
    chk("b2b_spacing", cyc, WIDTH + 1);
    @(negedge clk);
    chk("b2b_sum", {28'd0, sum}, 32'd4);

    // Abort mid-RUN: everything clears, no done pulse follows.
    start_op(4'd9, 4'd9, 1'b0, 1'b0);
    held = exp_q.pop_back();
    chk("abort_model", {27'd0, held}, 32'd18);
    @(negedge clk);
    done_snap = n_done;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_sum", {28'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, c_out}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_no_done", n_done, done_snap);
    chk("abort_sum_kept0", {28'd0, sum}, 32'd0);

    // Exhaustive sweep of every operand, carry and mode combination.
    for (int m = 0; m < 2; m++)
      for (int ci = 0; ci < 2; ci++)
        for (int ia = 0; ia < 16; ia++)
          for (int ib = 0; ib < 16; ib++) begin
            start_op(4'(ia), 4'(ib), 1'(ci), 1'(m));
            wait_done("exh", cyc);
          end

    @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_and_sub.md
# serial_add_and_sub

Bit-serial adder/subtractor: captures two WIDTH-bit operands, a carry-in and a mode bit on a start handshake, then computes `sum = a + (b ^ {WIDTH{M}}) + c_in` one bit per clock using a single full-adder cell and a carry flip-flop. It is the area-minimal, sequential counterpart of the combinational ripple-carry add/sub unit and produces bit-identical `sum` and `c_out` for every input. Results are flagged with a one-cycle `done` pulse and held until the next operation.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE or DONE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- c_in  input  1  carry into bit 0, captured on accepted start
- M  input  1  mode: 0 add, 1 subtract (B inverted), captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when result becomes valid
- sum  output  WIDTH  registered result, held until next completion
- c_out  output  1  registered carry out of bit WIDTH-1

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture a, b^{WIDTH{M}}, c_in into operand shift registers and carry FF; clear bit counter; go RUN.
- RUN: each cycle the full adder consumes LSBs of both shift registers plus carry FF; sum bit shifts into internal result shift register from the MSB end; operands shift right; carry FF updates; counter increments.
- After WIDTH RUN cycles: load `sum` from result shift register (with final bit), load `c_out` from final carry; go DONE.
- DONE: done=1 for exactly this cycle. start=1 here → capture as in IDLE and go RUN (back-to-back); else go IDLE.
- start during RUN is ignored; no queuing.
- Inputs a, b, c_in, M may change freely after capture without affecting the operation in flight.
- `sum`/`c_out` change only on the completion edge; partial results never appear on outputs.
- Subtraction semantics: M=1, c_in=1 gives two's-complement a−b; c_out=1 means no borrow (a ≥ b unsigned). M=1, c_in=0 gives a−b−1. Overflow is not flagged; wrap mod 2^WIDTH.

## Timing
- Reset (async assert, sync deassert release by clk): state IDLE, busy=0, done=0, sum=0, c_out=0, shift registers, counter and carry FF cleared.
- Start accepted at edge k → busy=1 from edge k to edge k+WIDTH; result and done=1 visible after edge k+WIDTH; done falls after edge k+WIDTH+1.
- Latency: WIDTH cycles from accepting edge to result; throughput one op per WIDTH+1 cycles when start is held high (accepted again in DONE).
- reset_n low mid-RUN: operation abandoned immediately, all outputs to reset values; no done pulse for the aborted operation.
- busy and done are never high simultaneously.
- Counter width: $clog2(WIDTH); terminal count WIDTH-1.

## Structure
- Shared package/include: state encoding localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2); no other shared constants.
- One sub-module: `full_adder` (a, b, c_in → s, c_out), instantiated once; same cell used by the ripple-carry units.
- Top contains FSM, counter, two operand shift registers, result shift register, carry FF, output registers.

## Test plan
- Reset: hold reset_n=0 with random inputs, start=1 → busy=0, done=0, sum=0, c_out=0; no operation begins until release.
- Add: a=5, b=7, c_in=0, M=0 → done after 4 cycles, sum=12, c_out=0; a=15, b=2, M=0, c_in=0 → sum=1, c_out=1.
- Subtract: a=13, b=7, M=1, c_in=1 → sum=6, c_out=1; a=2, b=6, M=1, c_in=1 → sum=12 (4'hC), c_out=0.
- Busy/hold: start a=7,b=1,M=1,c_in=1, then pulse start with a=0,b=0 during RUN and change inputs → ignored; sum=6, c_out=1; outputs stay until next completion.
- Back-to-back and abort: hold start=1 across two ops (4+3, then 1+3) → done pulses 5 cycles apart, sums 7 then 4; assert reset_n mid-RUN → outputs cleared, no done.
- Exhaustive: all a, b, c_in, M (1024 cases) vs. reference model a+(b^{4{M}})+c_in → zero mismatches.
